// File: rtl/umi_fir_filter_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// umi_fir_filter_pkg : default widths and output-width helper for the FIR core
// Revision: 1.0
//------------------------------------------------------------------------------
package umi_fir_filter_pkg;

   localparam int FIR_DW    = 16;
   localparam int FIR_NTAPS = 8;
   localparam int FIR_CW    = FIR_DW * FIR_NTAPS;

   // Full-precision accumulator width: product width plus log2 of the tap count
   function automatic int fir_ow(input int dw, input int ntaps);
      return 2 * dw + $clog2(ntaps);
   endfunction

   localparam int FIR_OW = fir_ow(FIR_DW, FIR_NTAPS);

endpackage
`default_nettype wire

// File: rtl/umi_fir_filter_mac.sv
`default_nettype none
//------------------------------------------------------------------------------
// umi_fir_filter_mac : stage-1 tap products and stage-2 adder tree, enable-gated
// Revision: 1.0
//------------------------------------------------------------------------------
module umi_fir_filter_mac
   import umi_fir_filter_pkg::*;
#(
   parameter int DW    = FIR_DW,
   parameter int NTAPS = FIR_NTAPS,
   parameter int CW    = FIR_CW,
   parameter int OW    = fir_ow(FIR_DW, FIR_NTAPS)
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          clear,
   input  logic          en,
   input  logic          in_valid,
   input  logic [CW-1:0] coeff,
   input  logic [DW-1:0] xnext [NTAPS],
   output logic          out_valid,
   output logic [OW-1:0] sum
);

   logic [2*DW-1:0] tap_ext  [NTAPS];
   logic [2*DW-1:0] samp_ext [NTAPS];
   logic [2*DW-1:0] prod     [NTAPS];
   logic [2*DW-1:0] p        [NTAPS];
   logic [OW-1:0]   acc;
   logic            s1_valid;
   logic            s2_valid;

   // Operands are sign-extended to product width so the low 2*DW bits are exact
   for (genvar i = 0; i < NTAPS; i++) begin : g_tap
      assign tap_ext[i]  = {{DW{coeff[DW*i+DW-1]}}, coeff[DW*i +: DW]};
      assign samp_ext[i] = {{DW{xnext[i][DW-1]}}, xnext[i]};
      assign prod[i]     = tap_ext[i] * samp_ext[i];
   end

   always_comb begin
      acc = '0;
      for (int i = 0; i < NTAPS; i++) begin
         acc = acc + {{(OW-2*DW){p[i][2*DW-1]}}, p[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         for (int i = 0; i < NTAPS; i++) p[i] <= '0;
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         sum      <= '0;
      end else begin
         if (clear) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
         end else if (en) begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            for (int i = 0; i < NTAPS; i++) p[i] <= prod[i];
            sum <= acc;
         end
      end
   end

   assign out_valid = s2_valid;

endmodule
`default_nettype wire

// File: rtl/umi_fir_filter_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// umi_fir_filter_core : streaming FIR with delay line, handshakes and flush
// Revision: 1.0
//------------------------------------------------------------------------------
module umi_fir_filter_core
   import umi_fir_filter_pkg::*;
#(
   parameter int DW    = FIR_DW,
   parameter int NTAPS = FIR_NTAPS,
   parameter int CW    = FIR_CW,
   parameter int OW    = fir_ow(FIR_DW, FIR_NTAPS)
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic [CW-1:0] coeff,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data
);

   logic [DW-1:0] x     [NTAPS];
   logic [DW-1:0] xnext [NTAPS];
   logic          rdy_q;
   logic          en;
   logic          in_fire;

   // rdy_q keeps in_ready low until the first edge after reset release
   assign en       = ~(out_valid & ~out_ready);
   assign in_ready = rdy_q & en & ~flush;
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      xnext[0] = in_data;
      for (int i = 1; i < NTAPS; i++) xnext[i] = x[i-1];
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         rdy_q <= 1'b0;
         for (int i = 0; i < NTAPS; i++) x[i] <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (flush) begin
            for (int i = 0; i < NTAPS; i++) x[i] <= '0;
         end else if (in_fire) begin
            for (int i = 0; i < NTAPS; i++) x[i] <= xnext[i];
         end
      end
   end

   umi_fir_filter_mac #(
      .DW    (DW),
      .NTAPS (NTAPS),
      .CW    (CW),
      .OW    (OW)
   ) u_mac (
      .clk       (clk),
      .nreset    (nreset),
      .clear     (flush),
      .en        (en),
      .in_valid  (in_fire),
      .coeff     (coeff),
      .xnext     (xnext),
      .out_valid (out_valid),
      .sum       (out_data)
   );

endmodule
`default_nettype wire
